phase_run_sequencer: RTL and testbench

- Run controller in front of the phase extraction datapath: on a start request it sequences RUNS acquisitions, each capturing 2^FFT_DEPTH antenna samples into the FFT input buffer, then triggering the FFT and waiting for completion.
- Sits in the main clk domain. Samples arrive already synchronised from the 20 MHz sampling domain as single-cycle sample_valid strobes.
- Reports the run index, busy/done status and a timeout error to the top level.

---
 rtl/phase_run_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_phase_run_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_run_sequencer.sv
// -----------------------------------------------------------------------------
// phase_run_sequencer
//
// Run controller in front of the phase extraction datapath. A start request
// launches a sequence of RUNS acquisitions. Each acquisition writes
// 2^FFT_DEPTH antenna samples into the FFT input buffer, pulses fft_start and
// then waits for fft_done. If fft_done does not arrive within TIMEOUT cycles,
// a sticky error is raised and the sequence ends.
//
// Ports
//   clk           main clock
//   reset_n       synchronous reset, active-low (sampled on clk)
//   start         one-cycle request to begin a sequence (used only in IDLE)
//   abort         one-cycle request to cancel a running sequence
//   sample_valid  single-cycle strobe, qualified sample this cycle
//   sample        antenna sample, two's complement, passed through untouched
//   buf_we        FFT buffer write enable (registered, 1 cycle after strobe)
//   buf_addr      FFT buffer write address
//   buf_data      FFT buffer write data
//   fft_start     one-cycle FFT trigger
//   fft_done      FFT completion strobe (only sampled while waiting)
//   run_idx       index of the current run, 0..RUNS-1
//   busy          high whenever the sequencer is not idle
//   done          one-cycle end-of-sequence pulse
//   error         sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module phase_run_sequencer #(
    parameter int SINK_WIDTH = 14,
    parameter int FFT_DEPTH  = 11,
    parameter int RUNS       = 3,
    parameter int TIMEOUT    = 65535
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    sample_valid,
    input  logic [SINK_WIDTH-1:0]   sample,
    output logic                    buf_we,
    output logic [FFT_DEPTH-1:0]    buf_addr,
    output logic [SINK_WIDTH-1:0]   buf_data,
    output logic                    fft_start,
    input  logic                    fft_done,
    output logic [$clog2(RUNS):0]   run_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int RIDX_W = $clog2(RUNS) + 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_TRIG    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [FFT_DEPTH-1:0] ADDR_LAST = {FFT_DEPTH{1'b1}};
    localparam logic [FFT_DEPTH-1:0] ADDR_ONE  = FFT_DEPTH'(1);
    localparam logic [RIDX_W-1:0]    RUN_LAST  = RIDX_W'(RUNS - 1);
    localparam logic [RIDX_W-1:0]    RUN_ONE   = RIDX_W'(1);
    localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]      TO_ONE    = TO_W'(1);

    logic [2:0]            state_r;
    logic [2:0]            state_nxt_s;
    logic [FFT_DEPTH-1:0]  addr_cnt_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic [RIDX_W-1:0]     run_idx_r;
    logic                  buf_we_r;
    logic [FFT_DEPTH-1:0]  buf_addr_r;
    logic [SINK_WIDTH-1:0] buf_data_r;
    logic                  fft_start_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;

    // Decoded one-cycle events produced by the next-state logic
    logic start_acc_s;   // start accepted in IDLE
    logic wr_s;          // sample captured this cycle
    logic trig_s;        // FFT trigger issued this cycle
    logic run_adv_s;     // completed run, more runs to go
    logic timeout_s;     // wait budget exhausted without fft_done
    logic wait_tick_s;   // one more wait cycle without fft_done

    // Next-state and event decode; abort outranks everything except in IDLE,
    // where start is the only input that matters.
    always_comb begin
        state_nxt_s = state_r;
        start_acc_s = 1'b0;
        wr_s        = 1'b0;
        trig_s      = 1'b0;
        run_adv_s   = 1'b0;
        timeout_s   = 1'b0;
        wait_tick_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (sample_valid) begin
                    wr_s = 1'b1;
                    if (addr_cnt_r == ADDR_LAST) begin
                        state_nxt_s = ST_TRIG;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_TRIG: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    trig_s      = 1'b1;
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (fft_done) begin
                    // fft_done beats a timeout landing on the same cycle
                    if (run_idx_r == RUN_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        run_adv_s   = 1'b1;
                        state_nxt_s = ST_CAPTURE;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    wait_tick_s = 1'b1;
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Buffer address counter; wraps naturally after the last address
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_cnt_r <= {FFT_DEPTH{1'b0}};
        end else if (start_acc_s) begin
            addr_cnt_r <= {FFT_DEPTH{1'b0}};
        end else if (wr_s) begin
            addr_cnt_r <= addr_cnt_r + ADDR_ONE;
        end else begin
            addr_cnt_r <= addr_cnt_r;
        end
    end

    // Buffer write port: one-cycle registered copy of the accepted strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_we_r   <= 1'b0;
            buf_addr_r <= {FFT_DEPTH{1'b0}};
            buf_data_r <= {SINK_WIDTH{1'b0}};
        end else if (wr_s) begin
            buf_we_r   <= 1'b1;
            buf_addr_r <= addr_cnt_r;
            buf_data_r <= sample;
        end else begin
            buf_we_r   <= 1'b0;
            buf_addr_r <= buf_addr_r;
            buf_data_r <= buf_data_r;
        end
    end

    // FFT trigger pulse, visible in the first wait cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fft_start_r <= 1'b0;
        end else begin
            fft_start_r <= trig_s;
        end
    end

    // Wait-cycle counter, restarted every time the FFT is triggered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == ST_TRIG) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (wait_tick_s) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Run index; holds its last value after the sequence ends or aborts
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run_idx_r <= {RIDX_W{1'b0}};
        end else if (start_acc_s) begin
            run_idx_r <= {RIDX_W{1'b0}};
        end else if (run_adv_s) begin
            run_idx_r <= run_idx_r + RUN_ONE;
        end else begin
            run_idx_r <= run_idx_r;
        end
    end

    // Sticky timeout flag; survives abort, cleared only by an accepted start
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            error_r <= 1'b0;
        end else if (start_acc_s) begin
            error_r <= 1'b0;
        end else if (timeout_s) begin
            error_r <= 1'b1;
        end else begin
            error_r <= error_r;
        end
    end

    // Status flags track the state being entered so busy and done drop together
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign buf_we    = buf_we_r;
    assign buf_addr  = buf_addr_r;
    assign buf_data  = buf_data_r;
    assign fft_start = fft_start_r;
    assign run_idx   = run_idx_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign error     = error_r;

endmodule

// File: tb/tb_phase_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_run_sequencer
//
// Scoreboard bench. The stimulus process drives transactions and, from the
// sequencing rules, predicts which cycle each buffer write, FFT trigger and
// done pulse must appear in. A negedge monitor pops and compares those
// predictions independently of the stimulus.
// -----------------------------------------------------------------------------
module tb_phase_run_sequencer;

    localparam int SW      = 14;
    localparam int FD      = 3;
    localparam int RUNS    = 2;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << FD;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          sample_valid;
    logic [SW-1:0] sample;
    logic          fft_done;
    logic          buf_we;
    logic [FD-1:0] buf_addr;
    logic [SW-1:0] buf_data;
    logic          fft_start;
    logic [1:0]    run_idx;
    logic          busy;
    logic          done;
    logic          error;

    phase_run_sequencer #(
        .SINK_WIDTH (SW),
        .FFT_DEPTH  (FD),
        .RUNS       (RUNS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .sample_valid (sample_valid),
        .sample       (sample),
        .buf_we       (buf_we),
        .buf_addr     (buf_addr),
        .buf_data     (buf_data),
        .fft_start    (fft_start),
        .fft_done     (fft_done),
        .run_idx      (run_idx),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Cycle number of the current clock period
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; int a; int d; } wr_t;
    typedef struct { int c; int e; } dn_t;

    wr_t wq[$];
    int  fq[$];
    dn_t dq[$];

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the sequence
    int m_run = 0;
    int m_wr  = 0;
    int m_err = 0;
    int fs_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare every DUT event against the oldest prediction
    wr_t mw;
    dn_t md;
    int  mf;
    always @(negedge clk) begin
        if (wq.size() > 0 && wq[0].c < cyc) begin
            mw = wq.pop_front();
            checks++; errors++;
            $display("FAIL write_missing: got no write, expected addr %0d data %0d at cycle %0d", mw.a, mw.d, mw.c);
        end
        if (fq.size() > 0 && fq[0] < cyc) begin
            mf = fq.pop_front();
            checks++; errors++;
            $display("FAIL fft_start_missing: got no pulse, expected at cycle %0d", mf);
        end
        if (dq.size() > 0 && dq[0].c < cyc) begin
            md = dq.pop_front();
            checks++; errors++;
            $display("FAIL done_missing: got no pulse, expected at cycle %0d", md.c);
        end
        if (buf_we) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr %0d data %0d at cycle %0d, expected no write", buf_addr, buf_data, cyc);
            end else begin
                mw = wq.pop_front();
                if (mw.c != cyc || mw.a != int'(buf_addr) || mw.d != int'(buf_data)) begin
                    errors++;
                    $display("FAIL write: got cyc %0d addr %0d data %0d, expected cyc %0d addr %0d data %0d",
                             cyc, buf_addr, buf_data, mw.c, mw.a, mw.d);
                end
            end
        end
        if (fft_start) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL fft_start_unexpected: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mf = fq.pop_front();
                if (mf != cyc) begin
                    errors++;
                    $display("FAIL fft_start: got cycle %0d expected cycle %0d", cyc, mf);
                end
            end
        end
        if (done) begin
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got pulse at cycle %0d, expected none", cyc);
            end else begin
                md = dq.pop_front();
                if (md.c != cyc || md.e != int'(error)) begin
                    errors++;
                    $display("FAIL done: got cyc %0d error %0d, expected cyc %0d error %0d", cyc, error, md.c, md.e);
                end
            end
        end
    end

    // Advance one clock period and release all pulse inputs
    task automatic step();
        @(posedge clk);
        #1;
        start        = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
        fft_done     = 1'b0;
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'($urandom_range(1, 0));
            fft_done     = 1'($urandom_range(1, 0));
            sample       = SW'($urandom);
            step();
        end
    endtask

    task automatic do_start(input bit with_abort);
        start        = 1'b1;
        abort        = with_abort;
        sample_valid = 1'($urandom_range(1, 0));
        sample       = SW'($urandom);
        m_run = 0; m_wr = 0; m_err = 0;
        step();
        chk("busy_after_start", int'(busy), 1);
        chk("error_after_start", int'(error), 0);
        chk("run_idx_after_start", int'(run_idx), 0);
    endtask

    // Capture n samples with random gaps; fft_done noise in gaps is ignored
    task automatic capture_run(input int n, input int max_gap, input bit det);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g < gap; g++) begin
                fft_done = 1'($urandom_range(1, 0));
                step();
            end
            sample_valid = 1'b1;
            sample = det ? SW'(i) : SW'($urandom);
            wq.push_back('{cyc + 1, m_wr, int'(sample)});
            m_wr++;
            if (m_wr == DEPTH) begin
                fs_cyc = cyc + 2;
                fq.push_back(fs_cyc);
                m_wr = 0;
            end
            step();
        end
    endtask

    task automatic finish_done();
        chk("busy_during_done", int'(busy), 1);
        step();
        chk("busy_after_done", int'(busy), 0);
        chk("done_width", int'(done), 0);
        chk("run_idx_hold", int'(run_idx), m_run);
        chk("error_at_end", int'(error), m_err);
    endtask

    // Return fft_done k cycles after the visible fft_start; k>=TIMEOUT withholds it
    task automatic wait_fft(input int k, output bit ended);
        int target;
        ended = 1'b0;
        if (k < TIMEOUT) begin
            target = fs_cyc + k;
        end else begin
            target = fs_cyc + TIMEOUT;
            dq.push_back('{target, 1});
            m_err = 1;
        end
        while (cyc < fs_cyc) step();
        while (cyc < target) begin
            sample_valid = 1'($urandom_range(1, 0));
            sample       = SW'($urandom);
            step();
        end
        if (k < TIMEOUT) begin
            fft_done     = 1'b1;
            sample_valid = 1'($urandom_range(1, 0));
            if (m_run == RUNS - 1) begin
                dq.push_back('{cyc + 1, 0});
                ended = 1'b1;
            end else begin
                m_run++;
            end
            step();
            if (ended) begin
                finish_done();
            end else begin
                chk("run_idx_advance", int'(run_idx), m_run);
            end
        end else begin
            ended = 1'b1;
            finish_done();
        end
    endtask

    task automatic run_seq(input int max_gap, input int k0, input int k1);
        bit ended;
        for (int r = 0; r < RUNS; r++) begin
            capture_run(DEPTH, max_gap, 1'b0);
            wait_fft((r == 0) ? k0 : k1, ended);
            if (ended) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ended;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        sample_valid = 1'b0; fft_done = 1'b0; sample = '0;
        step(); step(); step();
        reset_n = 1'b1;
        chk("reset_buf_we", int'(buf_we), 0);
        chk("reset_buf_addr", int'(buf_addr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_error", int'(error), 0);
        idle_noise(4);

        // Deterministic full sequence: back-to-back samples, fft_done after 5
        do_start(1'b0);
        capture_run(DEPTH, 0, 1'b1);
        wait_fft(5, ended);
        capture_run(DEPTH, 0, 1'b0);
        wait_fft(5, ended);
        idle_noise(3);

        // Withheld fft_done: timeout error, sticky until the next start
        do_start(1'b0);
        capture_run(DEPTH, 2, 1'b0);
        wait_fft(1000, ended);
        idle_noise(3);
        chk("error_sticky", int'(error), 1);
        do_start(1'b0);
        run_seq(1, TIMEOUT - 1, 0);
        idle_noise(2);

        // Abort mid run 1, with a redundant start just before it
        do_start(1'b1);
        capture_run(DEPTH, 1, 1'b0);
        wait_fft(3, ended);
        capture_run(4, 1, 1'b0);
        start = 1'b1; sample_valid = 1'b1; sample = SW'($urandom);
        wq.push_back('{cyc + 1, m_wr, int'(sample)});
        m_wr++;
        step();
        chk("run_idx_ignore_start", int'(run_idx), 1);
        abort = 1'b1; sample_valid = 1'b1; sample = SW'($urandom);
        step();
        chk("busy_after_abort", int'(busy), 0);
        chk("run_idx_after_abort", int'(run_idx), 1);
        chk("error_after_abort", int'(error), 0);
        idle_noise(6);

        // Reset mid-capture after 3 writes; reset outranks start and strobe
        do_start(1'b0);
        capture_run(3, 1, 1'b0);
        reset_n = 1'b0; start = 1'b1; sample_valid = 1'b1; sample = SW'($urandom);
        step();
        reset_n = 1'b1;
        m_run = 0; m_wr = 0; m_err = 0;
        chk("rst_mid_buf_we", int'(buf_we), 0);
        chk("rst_mid_buf_addr", int'(buf_addr), 0);
        chk("rst_mid_buf_data", int'(buf_data), 0);
        chk("rst_mid_fft_start", int'(fft_start), 0);
        chk("rst_mid_run_idx", int'(run_idx), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_error", int'(error), 0);
        do_start(1'b0);
        run_seq(2, 2, 7);
        idle_noise(2);

        // Randomized sequences, including timeouts and boundary fft_done
        for (int s = 0; s < 8; s++) begin
            do_start(1'($urandom_range(1, 0)));
            run_seq(2, $urandom_range(TIMEOUT + 3, 0), $urandom_range(TIMEOUT + 3, 0));
            idle_noise($urandom_range(3, 0));
        end

        idle_noise(4);
        checks++;
        if (wq.size() != 0 || fq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d writes %0d triggers %0d dones outstanding, expected 0",
                     wq.size(), fq.size(), dq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
